// File: rtl/tree_pkg.sv
// Shared constants for the tree loader: packed node field positions, bus widths
// and the loader FSM state encoding.
package tree_pkg;

  localparam int unsigned W_ADDR    = 10;
  localparam int unsigned NODE_SIZE = 32;
  localparam int unsigned W_DATA    = 12;
  localparam int unsigned W_CONF    = 10;

  localparam int unsigned PARENT_HI = 31;
  localparam int unsigned PARENT_LO = 22;
  localparam int unsigned ACTION_HI = 21;
  localparam int unsigned ACTION_LO = 19;
  localparam int unsigned REWARD_HI = 18;
  localparam int unsigned REWARD_LO = 7;
  localparam int unsigned WEIGHT_HI = 6;
  localparam int unsigned WEIGHT_LO = 0;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StConf  = 3'd1;
  localparam logic [2:0] StFetch = 3'd2;
  localparam logic [2:0] StPar   = 3'd3;
  localparam logic [2:0] StAct   = 3'd4;
  localparam logic [2:0] StRew   = 3'd5;
  localparam logic [2:0] StWgt   = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

endpackage

// File: rtl/tree_node_unpack.sv
// Combinational split of a packed node word into four W_DATA-wide fields.
// Reward is passed through raw (12-bit two's complement); the rest zero-extend.
module tree_node_unpack
  import tree_pkg::*;
(
  input  logic [NODE_SIZE-1:0] word_i,
  output logic [W_DATA-1:0]    parent_o,
  output logic [W_DATA-1:0]    action_o,
  output logic [W_DATA-1:0]    reward_o,
  output logic [W_DATA-1:0]    weight_o
);

  assign parent_o = W_DATA'(word_i[PARENT_HI:PARENT_LO]);
  assign action_o = W_DATA'(word_i[ACTION_HI:ACTION_LO]);
  assign reward_o = W_DATA'(word_i[REWARD_HI:REWARD_LO]);
  assign weight_o = W_DATA'(word_i[WEIGHT_HI:WEIGHT_LO]);

endmodule

// File: rtl/tree_loader.sv
// Host-side writer for treeval: takes a load command plus a stream of packed node
// words and emits conf_nodes followed by four one-hot field strobes per node.
module tree_loader
  import tree_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [W_CONF-1:0]    cmd_count,
  output logic                 busy,
  output logic                 cmd_err,
  input  logic                 in_valid,
  input  logic [NODE_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 conf_nodes,
  output logic [W_CONF-1:0]    conf_data,
  output logic                 mem_par,
  output logic                 mem_act,
  output logic                 mem_rew,
  output logic                 mem_weight,
  output logic [W_ADDR-1:0]    mem_addr,
  output logic [W_DATA-1:0]    mem_data,
  output logic                 done
);

  logic [2:0]           state_q, state_d;
  logic [W_CONF-1:0]    count_q, count_d;
  logic [W_ADDR-1:0]    addr_ctr_q, addr_ctr_d;
  logic [NODE_SIZE-1:0] word_q, word_d;

  logic                 busy_q, busy_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 in_ready_q, in_ready_d;
  logic                 conf_nodes_q, conf_nodes_d;
  logic [W_CONF-1:0]    conf_data_q, conf_data_d;
  logic                 mem_par_q, mem_par_d;
  logic                 mem_act_q, mem_act_d;
  logic                 mem_rew_q, mem_rew_d;
  logic                 mem_weight_q, mem_weight_d;
  logic [W_ADDR-1:0]    mem_addr_q, mem_addr_d;
  logic [W_DATA-1:0]    mem_data_q, mem_data_d;
  logic                 done_q, done_d;

  logic                 hs;
  logic                 last_node;
  logic [W_DATA-1:0]    f_parent, f_action, f_reward, f_weight;

  // in_ready_q is only ever high in FETCH and non-last WGT, so hs is scoped to them.
  assign hs        = in_valid & in_ready_q;
  assign word_d    = hs ? in_data : word_q;
  assign last_node = (addr_ctr_q == W_ADDR'(count_q - W_CONF'(1)));

  tree_node_unpack u_unpack (
    .word_i   (word_d),
    .parent_o (f_parent),
    .action_o (f_action),
    .reward_o (f_reward),
    .weight_o (f_weight)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    addr_ctr_d   = addr_ctr_q;
    busy_d       = busy_q;
    cmd_err_d    = 1'b0;
    in_ready_d   = 1'b0;
    conf_nodes_d = 1'b0;
    conf_data_d  = conf_data_q;
    mem_par_d    = 1'b0;
    mem_act_d    = 1'b0;
    mem_rew_d    = 1'b0;
    mem_weight_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    done_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_count != '0) begin
            count_d      = cmd_count;
            addr_ctr_d   = '0;
            busy_d       = 1'b1;
            conf_nodes_d = 1'b1;
            conf_data_d  = cmd_count;
            state_d      = StConf;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      StConf: begin
        in_ready_d = 1'b1;
        state_d    = StFetch;
      end
      StFetch: begin
        if (hs) begin
          mem_par_d  = 1'b1;
          mem_addr_d = addr_ctr_q;
          mem_data_d = f_parent;
          state_d    = StPar;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      StPar: begin
        mem_act_d  = 1'b1;
        mem_data_d = f_action;
        state_d    = StAct;
      end
      StAct: begin
        mem_rew_d  = 1'b1;
        mem_data_d = f_reward;
        state_d    = StRew;
      end
      StRew: begin
        mem_weight_d = 1'b1;
        mem_data_d   = f_weight;
        in_ready_d   = ~last_node;
        state_d      = StWgt;
      end
      StWgt: begin
        if (last_node) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          addr_ctr_d = addr_ctr_q + W_ADDR'(1);
          if (hs) begin
            // Back-to-back node: skip FETCH to sustain four cycles per node.
            mem_par_d  = 1'b1;
            mem_addr_d = addr_ctr_d;
            mem_data_d = f_parent;
            state_d    = StPar;
          end else begin
            in_ready_d = 1'b1;
            state_d    = StFetch;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      addr_ctr_q   <= '0;
      word_q       <= '0;
      busy_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      conf_nodes_q <= 1'b0;
      conf_data_q  <= '0;
      mem_par_q    <= 1'b0;
      mem_act_q    <= 1'b0;
      mem_rew_q    <= 1'b0;
      mem_weight_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      addr_ctr_q   <= addr_ctr_d;
      word_q       <= word_d;
      busy_q       <= busy_d;
      cmd_err_q    <= cmd_err_d;
      in_ready_q   <= in_ready_d;
      conf_nodes_q <= conf_nodes_d;
      conf_data_q  <= conf_data_d;
      mem_par_q    <= mem_par_d;
      mem_act_q    <= mem_act_d;
      mem_rew_q    <= mem_rew_d;
      mem_weight_q <= mem_weight_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign cmd_err    = cmd_err_q;
  assign in_ready   = in_ready_q;
  assign conf_nodes = conf_nodes_q;
  assign conf_data  = conf_data_q;
  assign mem_par    = mem_par_q;
  assign mem_act    = mem_act_q;
  assign mem_rew    = mem_rew_q;
  assign mem_weight = mem_weight_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign done       = done_q;

endmodule
